// File: rtl/sw_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
// Shared definitions for the stopwatch and its mode commander:
//   - sw_mode_e   : one-hot stopwatch mode encoding (IDLE/CLEAR/RUNNING)
//   - cmd_state_e : mode-commander FSM states
//   - TIMER_W     : width of the shared press/settle down-counter
//   - MAX_PRESSES : number of button presses allowed per request
//   - is_legal_mode(): true when a 3-bit value is one of the three modes
// -----------------------------------------------------------------------------
package sw_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE    = 3'b100,
    MODE_CLEAR   = 3'b010,
    MODE_RUNNING = 3'b001
  } sw_mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_WAIT,
    S_RESP
  } cmd_state_e;

  localparam int         TIMER_W     = 8;
  localparam logic [1:0] MAX_PRESSES = 2'd2;

  function automatic logic is_legal_mode(input logic [2:0] m);
    return (m == MODE_IDLE) || (m == MODE_CLEAR) || (m == MODE_RUNNING);
  endfunction

endpackage

// File: rtl/sw_cmd_timer.sv
// -----------------------------------------------------------------------------
// sw_cmd_timer
// Loadable down-counter with an expire flag. The commander reuses a single
// instance for both the button press width and the post-release settle
// timeout, since the two intervals never overlap.
//
// Ports:
//   clk      in   system clock
//   rst_i    in   synchronous active-high reset (count -> 0)
//   load     in   load load_val this cycle (has priority over counting)
//   load_val in   value to load; the counter expires load_val+1 cycles later
//   expired  out  count is zero
// -----------------------------------------------------------------------------
module sw_cmd_timer
  import sw_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/sw_mode_commander.sv
// -----------------------------------------------------------------------------
// sw_mode_commander
// Drives the single button of a stop_watch until its mode feedback reaches a
// requested target mode. Each press is PRESS_CYCLES wide; after release the
// block waits up to SETTLE_CYCLES for the mode to change. At most two presses
// are issued per request. The outcome is reported with a one-cycle done_o or
// err_o pulse.
//
// Parameters:
//   PRESS_CYCLES   button_o high width in cycles (1..15)
//   SETTLE_CYCLES  cycles to wait for a mode change after release (2..255)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_i        in   synchronous active-high reset
//   req_valid_i  in   mode-change request valid
//   req_mode_i   in   one-hot target mode (IDLE=100, CLEAR=010, RUNNING=001)
//   req_ready_o  out  high only when idle; request accepted on valid & ready
//   mode_i       in   stop_watch mode feedback
//   button_o     out  registered button drive
//   done_o       out  one-cycle pulse: target reached
//   err_o        out  one-cycle pulse: illegal target, timeout, press limit
//   busy_o       out  high whenever not idle
//   abort_i      in   (only with SW_CMD_ABORT_EN) return to idle silently
//
// Optional feature: define SW_CMD_ABORT_EN to add the abort_i input.
// -----------------------------------------------------------------------------
module sw_mode_commander
  import sw_pkg::*;
#(
  parameter int PRESS_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       req_valid_i,
  input  logic [2:0] req_mode_i,
  output logic       req_ready_o,
  input  logic [2:0] mode_i,
  output logic       button_o,
  output logic       done_o,
  output logic       err_o,
  output logic       busy_o
`ifdef SW_CMD_ABORT_EN
  ,
  input  logic       abort_i
`endif
);

  // The timer expires load_val+1 cycles after loading, hence the -1.
  localparam logic [TIMER_W-1:0] PRESS_LOAD  = TIMER_W'(PRESS_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

  cmd_state_e state;
  logic [2:0] target;
  logic [2:0] pre_mode;    // mode seen before the most recent press
  logic [1:0] press_cnt;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_expired;

  logic accept;
  logic req_legal;
  logic req_hit;
  logic changed;
  logic at_target;
  logic press_limit;
  logic start_press;
  logic end_press;
  logic repress;

  assign req_ready_o = (state == S_IDLE);
  assign busy_o      = (state != S_IDLE);

  assign accept      = req_valid_i && (state == S_IDLE);
  assign req_legal   = is_legal_mode(req_mode_i);
  assign req_hit     = (mode_i == req_mode_i);
  assign changed     = (mode_i != pre_mode);
  assign at_target   = (mode_i == target);
  assign press_limit = (press_cnt == MAX_PRESSES);

  // Events that (re)start the shared timer. A detected change is evaluated
  // before the timeout, so a change on the expiring cycle still wins.
  assign start_press = accept && req_legal && !req_hit;
  assign end_press   = (state == S_PRESS) && tmr_expired;
  assign repress     = (state == S_WAIT) && changed && !at_target && !press_limit;

  assign tmr_load = start_press || end_press || repress;
  assign tmr_val  = end_press ? SETTLE_LOAD : PRESS_LOAD;

  sw_cmd_timer #(
    .W        (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst_i    (rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state     <= S_IDLE;
      button_o  <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      target    <= '0;
      pre_mode  <= '0;
      press_cnt <= '0;
    end
`ifdef SW_CMD_ABORT_EN
    else if (abort_i && (state != S_IDLE)) begin
      state    <= S_IDLE;
      button_o <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end
`endif
    else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!req_legal) begin
              state <= S_RESP;
              err_o <= 1'b1;
            end else if (req_hit) begin
              state  <= S_RESP;
              done_o <= 1'b1;
            end else begin
              state     <= S_PRESS;
              button_o  <= 1'b1;
              target    <= req_mode_i;
              pre_mode  <= mode_i;
              press_cnt <= 2'd1;
            end
          end
        end

        S_PRESS: begin
          if (tmr_expired) begin
            state    <= S_WAIT;
            button_o <= 1'b0;
          end
        end

        S_WAIT: begin
          if (changed) begin
            if (at_target) begin
              state  <= S_RESP;
              done_o <= 1'b1;
            end else if (press_limit) begin
              state <= S_RESP;
              err_o <= 1'b1;
            end else begin
              state     <= S_PRESS;
              button_o  <= 1'b1;
              pre_mode  <= mode_i;
              press_cnt <= press_cnt + 2'd1;
            end
          end else if (tmr_expired) begin
            state <= S_RESP;
            err_o <= 1'b1;
          end
        end

        S_RESP: begin
          state <= S_IDLE;
        end

        default: begin
          state    <= S_IDLE;
          button_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
